// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request bus between the fetch unit and instruction memory.
//   imem_req    fetch request (fetch unit -> memory)
//   imem_addr   byte address of the fetch, held stable while imem_req is high
//   imem_ready  handshake complete; imem_rdata valid in the same cycle
//   imem_rdata  fetched instruction word
// master: fetch unit side; slave: memory side.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage of the 16-bit RISC core.
// Owns the program counter, fetches over the imem req/ready bus, and writes
// the IF/ID pipeline register. Execute-stage redirects (jump / beq / bne)
// reload the PC and flush IF/ID; a response still in flight when the redirect
// arrives is dropped.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   imem              instruction-memory bus (master side)
//   id_stall          decode cannot accept; IF/ID holds
//   ex_jump/beq/bne   execute-stage control, ex_zero ALU zero flag
//   ex_pc_plus2       PC+2 of the execute-stage instruction
//   ex_imm            signed branch offset in halfwords
//   ex_jaddr          jump target field
//   if_id_valid/instr/pc_plus2/opcode  IF/ID pipeline register outputs
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                      clk,
  input  logic                      rst,
  instr_fetch_unit_if.master        imem,
  input  logic                      id_stall,
  input  logic                      ex_jump,
  input  logic                      ex_beq,
  input  logic                      ex_bne,
  input  logic                      ex_zero,
  input  logic [15:0]               ex_pc_plus2,
  input  logic [5:0]                ex_imm,
  input  logic [11:0]               ex_jaddr,
  output logic                      if_id_valid,
  output logic [15:0]               if_id_instr,
  output logic [15:0]               if_id_pc_plus2,
  output logic [3:0]                if_id_opcode
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  function automatic logic [15:0] jump_target(input logic [15:0] pc2,
                                               input logic [11:0] jaddr);
    return {pc2[15:13], jaddr, 1'b0};
  endfunction

  function automatic logic [15:0] branch_target(input logic [15:0] pc2,
                                                 input logic [5:0]  imm);
    logic signed [15:0] off;
    off = {{9{imm[5]}}, imm, 1'b0};
    return pc2 + off;
  endfunction

  logic [1:0]  state;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic        discard;
  logic [15:0] stale_addr;
  logic [15:0] skid_instr;
  logic [15:0] skid_pc_plus2;
  logic        redir;
  logic [15:0] target;
  logic        hs;
  logic        if_id_free;

  assign redir      = ex_jump | (ex_beq & ex_zero) | (ex_bne & ~ex_zero);
  assign target     = ex_jump ? jump_target(ex_pc_plus2, ex_jaddr)
                              : branch_target(ex_pc_plus2, ex_imm);
  assign hs         = (state == REQ) & imem.imem_ready;
  assign if_id_free = ~if_id_valid | ~id_stall;
  assign pc_inc     = pc + 16'd2;

  // req is decoded from state only, so an async reset drops it immediately.
  // While a discard is pending the bus keeps the pre-redirect address until
  // the outstanding response arrives; pc already holds the target.
  assign imem.imem_req  = (state == REQ);
  assign imem.imem_addr = discard ? stale_addr : pc;
  assign if_id_opcode   = if_id_instr[15:12];

  // ---- fetch control and IF/ID register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      discard        <= 1'b0;
      if_id_valid    <= 1'b0;
      if_id_instr    <= 16'h0000;
      if_id_pc_plus2 <= 16'h0000;
    end else if (redir) begin
      // Redirect wins in every state and flushes IF/ID even under id_stall.
      pc          <= target;
      if_id_valid <= 1'b0;
      state       <= REQ;
      if (state == REQ) begin
        if (hs)
          discard <= 1'b0;
        else
          discard <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          if (!id_stall) if_id_valid <= 1'b0;
        end
        REQ: begin
          if (hs && discard) begin
            discard <= 1'b0;
            if (!id_stall) if_id_valid <= 1'b0;
          end else if (hs && if_id_free) begin
            if_id_valid    <= 1'b1;
            if_id_instr    <= imem.imem_rdata;
            if_id_pc_plus2 <= pc_inc;
            pc             <= pc_inc;
          end else if (hs) begin
            pc    <= pc_inc;
            state <= HOLD;
          end else if (!id_stall) begin
            if_id_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!id_stall) begin
            if_id_valid    <= 1'b1;
            if_id_instr    <= skid_instr;
            if_id_pc_plus2 <= skid_pc_plus2;
            state          <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- skid and stale-address data registers ----
  always_ff @(posedge clk) begin
    if (!redir && hs && !discard && !if_id_free) begin
      skid_instr    <= imem.imem_rdata;
      skid_pc_plus2 <= pc_inc;
    end
    if (redir && (state == REQ) && !hs && !discard)
      stale_addr <= pc;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        id_stall;
  logic        ex_jump, ex_beq, ex_bne, ex_zero;
  logic [15:0] ex_pc_plus2;
  logic [5:0]  ex_imm;
  logic [11:0] ex_jaddr;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic [3:0]  if_id_opcode;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:32767];

  always #5 clk = ~clk;

  instr_fetch_unit_if bus();
  assign bus.imem_ready = ready;
  assign bus.imem_rdata = mem[bus.imem_addr[15:1]];

  instr_fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (bus),
    .id_stall       (id_stall),
    .ex_jump        (ex_jump),
    .ex_beq         (ex_beq),
    .ex_bne         (ex_bne),
    .ex_zero        (ex_zero),
    .ex_pc_plus2    (ex_pc_plus2),
    .ex_imm         (ex_imm),
    .ex_jaddr       (ex_jaddr),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .if_id_opcode   (if_id_opcode)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a running flag (post-reset idle cycle done), a held
  // word waiting for decode, a pending-drop flag with the address still on
  // the bus, the PC and the IF/ID contents.
  logic        m_run, m_held, m_drop, m_v;
  logic [15:0] m_pc, m_old, m_instr, m_pc2, m_held_instr, m_held_pc2;
  logic        m_reqon, m_hs, m_redir;
  logic [15:0] m_tgt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 1'b0; m_held = 1'b0; m_drop = 1'b0; m_v = 1'b0;
      m_pc = 16'h0000; m_instr = 16'h0000; m_pc2 = 16'h0000;
    end else begin
      m_reqon = m_run && !m_held;
      m_hs    = m_reqon && ready;
      m_redir = ex_jump || (ex_beq && ex_zero) || (ex_bne && !ex_zero);
      if (ex_jump)
        m_tgt = (ex_pc_plus2 & 16'hE000) | {3'b000, ex_jaddr, 1'b0};
      else
        m_tgt = 16'(int'(ex_pc_plus2) + 2 * int'($signed(ex_imm)));
      if (m_redir) begin
        if (m_reqon && !m_hs && !m_drop) begin
          m_drop = 1'b1;
          m_old  = m_pc;
        end else if (m_hs) begin
          m_drop = 1'b0;
        end
        m_held = 1'b0; m_run = 1'b1; m_pc = m_tgt; m_v = 1'b0;
      end else if (!m_run) begin
        m_run = 1'b1;
        if (!id_stall) m_v = 1'b0;
      end else if (m_held) begin
        if (!id_stall) begin
          m_v = 1'b1; m_instr = m_held_instr; m_pc2 = m_held_pc2; m_held = 1'b0;
        end
      end else if (m_hs && m_drop) begin
        m_drop = 1'b0;
        if (!id_stall) m_v = 1'b0;
      end else if (m_hs) begin
        if (!m_v || !id_stall) begin
          m_v = 1'b1; m_instr = mem[m_pc[15:1]]; m_pc2 = m_pc + 16'd2;
        end else begin
          m_held = 1'b1; m_held_instr = mem[m_pc[15:1]]; m_held_pc2 = m_pc + 16'd2;
        end
        m_pc = m_pc + 16'd2;
      end else if (!id_stall) begin
        m_v = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("req", bus.imem_req, m_run && !m_held);
    if (m_run && !m_held)
      chk("addr", bus.imem_addr, m_drop ? m_old : m_pc);
    chk("valid", if_id_valid, m_v);
    if (m_v) begin
      chk("instr", if_id_instr, m_instr);
      chk("pc_plus2", if_id_pc_plus2, m_pc2);
      chk("opcode", if_id_opcode, m_instr >> 12);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_clear();
    ex_jump = 0; ex_beq = 0; ex_bne = 0; ex_zero = 0;
    ex_pc_plus2 = 16'h0000; ex_imm = 6'h00; ex_jaddr = 12'h000;
  endtask

  initial begin
    rst = 1'b1; ready = 1'b1; id_stall = 1'b0;
    ex_clear();
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h2123; mem[1] = 16'h3456; mem[2] = 16'h4789;

    tick(); tick();
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_valid", if_id_valid, 1'b0);
    chk("rst_instr", if_id_instr, 16'h0000);
    chk("rst_pc2", if_id_pc_plus2, 16'h0000);
    chk("rst_addr", bus.imem_addr, 16'h0000);
    rst = 1'b0;

    // one idle cycle, then back-to-back fetches
    tick();
    chk("first_req", bus.imem_req, 1'b1);
    chk("first_addr", bus.imem_addr, 16'h0000);
    tick();
    chk("seq0_instr", if_id_instr, 16'h2123);
    chk("seq0_pc2", if_id_pc_plus2, 16'h0002);
    chk("seq0_op", if_id_opcode, 4'h2);
    chk("seq0_addr", bus.imem_addr, 16'h0002);
    tick();
    chk("seq1_instr", if_id_instr, 16'h3456);
    chk("seq1_pc2", if_id_pc_plus2, 16'h0004);
    tick();
    chk("seq2_instr", if_id_instr, 16'h4789);
    chk("seq2_pc2", if_id_pc_plus2, 16'h0006);
    chk("seq2_addr", bus.imem_addr, 16'h0006);

    // memory latency of three cycles
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_addr", bus.imem_addr, 16'h0006);
      chk("wait_valid", if_id_valid, 1'b0);
    end
    ready = 1'b1;
    tick();
    chk("lat_valid", if_id_valid, 1'b1);
    chk("lat_instr", if_id_instr, mem[3]);
    chk("lat_pc2", if_id_pc_plus2, 16'h0008);
    ready = 1'b0;
    tick();
    chk("lat_pulse", if_id_valid, 1'b0);

    // decode stall: second word goes to the skid, req drops
    ready = 1'b1; id_stall = 1'b1;
    tick();
    chk("st0_instr", if_id_instr, mem[4]);
    chk("st0_pc2", if_id_pc_plus2, 16'h000A);
    tick();
    chk("hold_req", bus.imem_req, 1'b0);
    chk("hold_instr", if_id_instr, mem[4]);
    tick();
    chk("hold_req2", bus.imem_req, 1'b0);
    id_stall = 1'b0;
    tick();
    chk("skid_instr", if_id_instr, mem[5]);
    chk("skid_pc2", if_id_pc_plus2, 16'h000C);
    chk("resume_addr", bus.imem_addr, 16'h000C);
    tick();
    chk("resume_instr", if_id_instr, mem[6]);
    chk("resume_pc2", if_id_pc_plus2, 16'h000E);

    // taken branch, then the same branch not taken
    ex_beq = 1; ex_zero = 1; ex_pc_plus2 = 16'h0010; ex_imm = 6'h3E;
    tick();
    chk("beq_addr", bus.imem_addr, 16'h000C);
    chk("beq_valid", if_id_valid, 1'b0);
    ex_zero = 0;
    tick();
    chk("beqnt_addr", bus.imem_addr, 16'h000E);
    chk("beqnt_valid", if_id_valid, 1'b1);
    ex_clear();

    // jump
    ex_jump = 1; ex_pc_plus2 = 16'hA002; ex_jaddr = 12'h123;
    tick();
    chk("jump_addr", bus.imem_addr, 16'hA246);
    chk("jump_valid", if_id_valid, 1'b0);
    ex_pc_plus2 = 16'h0000; ex_jaddr = 12'h004;
    tick();
    chk("j8_addr", bus.imem_addr, 16'h0008);

    // redirect to 0x0040 while 0x0008 is outstanding
    ready = 1'b0; ex_jaddr = 12'h020;
    tick();
    chk("pend_addr", bus.imem_addr, 16'h0008);
    chk("pend_req", bus.imem_req, 1'b1);
    ex_clear();
    tick();
    chk("pend_addr2", bus.imem_addr, 16'h0008);
    ready = 1'b1;
    tick();
    chk("drop_valid", if_id_valid, 1'b0);
    chk("drop_addr", bus.imem_addr, 16'h0040);
    tick();
    chk("tgt_instr", if_id_instr, mem[16'h0020]);
    chk("tgt_pc2", if_id_pc_plus2, 16'h0042);
    ready = 1'b0;
    tick();

    // asynchronous reset mid-request
    rst = 1'b1;
    #1;
    chk("arst_req", bus.imem_req, 1'b0);
    chk("arst_addr", bus.imem_addr, 16'h0000);
    ready = 1'b1;
    tick();
    chk("arst_req2", bus.imem_req, 1'b0);
    chk("arst_valid", if_id_valid, 1'b0);
    rst = 1'b0;
    tick();

    // PC wrap at the top of memory
    ex_jump = 1; ex_pc_plus2 = 16'hE000; ex_jaddr = 12'hFFF;
    tick();
    chk("wrap_addr0", bus.imem_addr, 16'hFFFE);
    ex_clear();
    tick();
    chk("wrap_pc2", if_id_pc_plus2, 16'h0000);
    chk("wrap_instr", if_id_instr, mem[15'h7FFF]);
    chk("wrap_addr1", bus.imem_addr, 16'h0000);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst         = (($urandom % 400) == 0);
      ready       = (($urandom % 10) < 6);
      id_stall    = (($urandom % 4) == 0);
      ex_jump     = (($urandom % 16) == 0);
      ex_beq      = (($urandom % 10) == 0);
      ex_bne      = (($urandom % 10) == 0);
      ex_zero     = 1'($urandom);
      ex_pc_plus2 = 16'($urandom);
      ex_imm      = 6'($urandom);
      ex_jaddr    = 12'($urandom);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
